// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file widths and write-port grant encoding.
// Consumers: wb_sched and wb_scoreboard (the latter built with WB_SCHED_SCOREBOARD_EN).
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

endpackage

// File: rtl/wb_sched_if.sv
// Write-back scheduler bus: ALU/load write requests, register-file write port, issue/stall.
// The issue/stall signals are only meaningful when WB_SCHED_SCOREBOARD_EN is defined.
interface wb_sched_if;
    import cpu_pkg::*;

    logic                    alu_req;
    logic [0:REG_ADDR_W-1]   alu_addr;
    logic [0:REG_DATA_W-1]   alu_data;
    logic                    alu_ack;
    logic                    ld_req;
    logic [0:REG_ADDR_W-1]   ld_addr;
    logic [0:REG_DATA_W-1]   ld_data;
    logic                    ld_ack;
    logic                    wr;
    logic [0:REG_ADDR_W-1]   c_addr;
    logic [0:REG_DATA_W-1]   c_data;
    logic                    issue_valid;
    logic [0:REG_ADDR_W-1]   issue_src_a;
    logic [0:REG_ADDR_W-1]   issue_src_b;
    logic [0:REG_ADDR_W-1]   issue_dst;
    logic                    stall;

    modport slave (
        input  alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
        input  issue_valid, issue_src_a, issue_src_b, issue_dst,
        output alu_ack, ld_ack, wr, c_addr, c_data, stall
    );

    modport master (
        output alu_req, alu_addr, alu_data, ld_req, ld_addr, ld_data,
        output issue_valid, issue_src_a, issue_src_b, issue_dst,
        input  alu_ack, ld_ack, wr, c_addr, c_data, stall
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: tracks registers with writes in flight and stalls issue on hazards.
// Instantiated by wb_sched only when WB_SCHED_SCOREBOARD_EN is defined.
module wb_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [0:REG_ADDR_W-1] issue_src_a,
    input  logic [0:REG_ADDR_W-1] issue_src_b,
    input  logic [0:REG_ADDR_W-1] issue_dst,
    input  logic                  wr,
    input  logic [0:REG_ADDR_W-1] c_addr,
    output logic                  stall
);

    logic [31:0] pending;
    logic [31:0] pending_next;

    assign stall = !reset && issue_valid &&
                   (pending[issue_src_a] || pending[issue_src_b] || pending[issue_dst]);

    // Clear first so a same-cycle set on the same bit wins.
    always_comb begin
        pending_next = pending;
        if (wr) begin
            pending_next[c_addr] = 1'b0;
        end
        if (issue_valid && !stall && (issue_dst != '0)) begin
            pending_next[issue_dst] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/wb_sched.sv
// Round-robin arbiter for the register file's single write port (ALU vs load return).
// Define WB_SCHED_SCOREBOARD_EN to add the pending-write scoreboard and issue stall.
module wb_sched
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    wb_sched_if.slave  bus
);

    logic                  last;
    logic                  alu_gnt;
    logic                  ld_gnt;
    logic                  wr_q;
    logic [0:REG_ADDR_W-1] c_addr_q;
    logic [0:REG_DATA_W-1] c_data_q;

    // Acks are suppressed during reset so no requester believes a dropped write landed.
    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (!reset) begin
            if (bus.alu_req && bus.ld_req) begin
                ld_gnt  = (last == GNT_ALU);
                alu_gnt = (last == GNT_LD);
            end else begin
                alu_gnt = bus.alu_req;
                ld_gnt  = bus.ld_req;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q     <= 1'b0;
            c_addr_q <= '0;
            c_data_q <= '0;
            last     <= GNT_ALU;
        end else begin
            wr_q <= 1'b0;
            if (alu_gnt) begin
                last <= GNT_ALU;
                if (bus.alu_addr != '0) begin
                    wr_q     <= 1'b1;
                    c_addr_q <= bus.alu_addr;
                    c_data_q <= bus.alu_data;
                end
            end else if (ld_gnt) begin
                last <= GNT_LD;
                if (bus.ld_addr != '0) begin
                    wr_q     <= 1'b1;
                    c_addr_q <= bus.ld_addr;
                    c_data_q <= bus.ld_data;
                end
            end
        end
    end

    assign bus.alu_ack = alu_gnt;
    assign bus.ld_ack  = ld_gnt;
    assign bus.wr      = wr_q;
    assign bus.c_addr  = c_addr_q;
    assign bus.c_data  = c_data_q;

`ifdef WB_SCHED_SCOREBOARD_EN
    logic sb_stall;

    wb_scoreboard u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_src_a (bus.issue_src_a),
        .issue_src_b (bus.issue_src_b),
        .issue_dst   (bus.issue_dst),
        .wr          (wr_q),
        .c_addr      (c_addr_q),
        .stall       (sb_stall)
    );

    assign bus.stall = sb_stall;
`else
    logic unused_issue;

    assign unused_issue = ^{bus.issue_valid, bus.issue_src_a, bus.issue_src_b, bus.issue_dst};
    assign bus.stall    = 1'b0;
`endif

endmodule
